// File: rtl/alu_sched.sv
// Round-robin scheduler that shares one registered-latency ALU between two requesters.
// Each accepted operation is returned to its owner with a one-cycle response strobe.
module alu_sched #(
    parameter int WIDTH   = 16,
    parameter int ALU_LAT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             r0_valid_i,
    input  logic             r1_valid_i,
    output logic             r0_ready_o,
    output logic             r1_ready_o,
    input  logic [WIDTH-1:0] r0_a_i,
    input  logic [WIDTH-1:0] r0_b_i,
    input  logic [WIDTH-1:0] r1_a_i,
    input  logic [WIDTH-1:0] r1_b_i,
    input  logic [2:0]       r0_sel_i,
    input  logic [2:0]       r1_sel_i,
    output logic             r0_rsp_valid_o,
    output logic             r1_rsp_valid_o,
    output logic [WIDTH-1:0] r0_rsp_q_o,
    output logic [WIDTH-1:0] r1_rsp_q_o,
    output logic [WIDTH-1:0] alu_a_o,
    output logic [WIDTH-1:0] alu_b_o,
    output logic [2:0]       alu_sel_o,
    input  logic [WIDTH-1:0] alu_q_i,
    output logic             busy_o,
    output logic             owner_o
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [2:0] LAT = 3'(ALU_LAT);

    state_t           state_q;
    logic [2:0]       cnt_q;
    logic             last_grant_q;
    logic             owner_q;
    logic             busy_q;
    logic [WIDTH-1:0] alu_a_q;
    logic [WIDTH-1:0] alu_b_q;
    logic [2:0]       alu_sel_q;
    logic [WIDTH-1:0] r0_result_q;
    logic [WIDTH-1:0] r1_result_q;
    logic             r0_rsp_valid_q;
    logic             r1_rsp_valid_q;
    logic             grant_d;
    logic             accept_d;

    // Under contention the requester that did not win last time goes first.
    always_comb begin
        grant_d = (r0_valid_i && r1_valid_i) ? ~last_grant_q : r1_valid_i;
    end

    assign r0_ready_o = (state_q == IDLE) && !reset && r0_valid_i && !grant_d;
    assign r1_ready_o = (state_q == IDLE) && !reset && r1_valid_i && grant_d;
    assign accept_d   = r0_ready_o || r1_ready_o;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            cnt_q          <= 3'd0;
            last_grant_q   <= 1'b1;
            owner_q        <= 1'b0;
            busy_q         <= 1'b0;
            alu_a_q        <= '0;
            alu_b_q        <= '0;
            alu_sel_q      <= 3'd0;
            r0_result_q    <= '0;
            r1_result_q    <= '0;
            r0_rsp_valid_q <= 1'b0;
            r1_rsp_valid_q <= 1'b0;
        end else begin
            r0_rsp_valid_q <= 1'b0;
            r1_rsp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept_d) begin
                        alu_a_q      <= grant_d ? r1_a_i   : r0_a_i;
                        alu_b_q      <= grant_d ? r1_b_i   : r0_b_i;
                        alu_sel_q    <= grant_d ? r1_sel_i : r0_sel_i;
                        owner_q      <= grant_d;
                        last_grant_q <= grant_d;
                        cnt_q        <= LAT;
                        busy_q       <= 1'b1;
                        state_q      <= WAIT;
                    end
                end
                // The counter runs one edge past ALU_LAT so the capture sees a settled result.
                WAIT: begin
                    if (cnt_q == 3'd0) begin
                        if (owner_q) begin
                            r1_result_q    <= alu_q_i;
                            r1_rsp_valid_q <= 1'b1;
                        end else begin
                            r0_result_q    <= alu_q_i;
                            r0_rsp_valid_q <= 1'b1;
                        end
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                RESP: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign r0_rsp_valid_o = r0_rsp_valid_q;
    assign r1_rsp_valid_o = r1_rsp_valid_q;
    assign r0_rsp_q_o     = r0_result_q;
    assign r1_rsp_q_o     = r1_result_q;
    assign alu_a_o        = alu_a_q;
    assign alu_b_o        = alu_b_q;
    assign alu_sel_o      = alu_sel_q;
    assign busy_o         = busy_q;
    assign owner_o        = owner_q;

endmodule
